// File: rtl/nasti_stream_pkg.sv
// nasti_stream_pkg: beat layout and FSM states shared by the NASTI stream mux/demux.
// NASTI_DEST_W bounds the DEST_WIDTH of any block that carries beats in stream_beat_t.
package nasti_stream_pkg;

    localparam int unsigned NASTI_DATA_W = 32;
    localparam int unsigned NASTI_STRB_W = NASTI_DATA_W / 8;
    localparam int unsigned NASTI_ID_W   = 4;
    localparam int unsigned NASTI_DEST_W = 4;
    localparam int unsigned NASTI_USER_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUTE,
        S_DROP
    } stream_state_e;

    typedef struct packed {
        logic [NASTI_DATA_W-1:0] data;
        logic [NASTI_STRB_W-1:0] strb;
        logic [NASTI_STRB_W-1:0] keep;
        logic                    last;
        logic [NASTI_ID_W-1:0]   id;
        logic [NASTI_DEST_W-1:0] dest;
        logic [NASTI_USER_W-1:0] user;
    } stream_beat_t;

endpackage

// File: rtl/nasti_stream_skid_buf.sv
// nasti_stream_skid_buf: 2-entry skid buffer; o_ready comes straight from a flop.
// Full throughput: the skid entry only fills when the output stalls.
module nasti_stream_skid_buf
    import nasti_stream_pkg::*;
#(
    parameter type T = stream_beat_t
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic i_valid,
    output logic o_ready,
    input  T     i_beat,
    output logic o_valid,
    input  logic i_ready,
    output T     o_beat
);

    logic r_valid;
    logic r_skid_valid;
    T     r_beat;
    T     r_skid_beat;
    logic w_in_hs;
    logic w_out_free;

    assign w_in_hs    = i_valid && !r_skid_valid;
    assign w_out_free = !r_valid || i_ready;
    assign o_ready    = !r_skid_valid;
    assign o_valid    = r_valid;
    assign o_beat     = r_beat;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_valid      <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            r_valid      <= r_skid_valid || w_in_hs;
            r_skid_valid <= 1'b0;
        end else if (w_in_hs) begin
            r_skid_valid <= 1'b1;
        end
    end

    // Payload flops carry no reset; their valid bits qualify them.
    always_ff @(posedge aclk) begin
        if (w_out_free) begin
            r_beat <= r_skid_valid ? r_skid_beat : i_beat;
        end else if (w_in_hs) begin
            r_skid_beat <= i_beat;
        end
    end

endmodule

// File: rtl/nasti_stream_demux.sv
// nasti_stream_demux: routes each NASTI stream packet to lane t_dest-DEST_BASE, drops out-of-range packets.
// Define NASTI_STREAM_DEMUX_REG_SLICE_EN to place a skid buffer between the master port and the router.
module nasti_stream_demux
    import nasti_stream_pkg::*;
#(
    parameter int unsigned N_PORT     = 2,
    parameter int unsigned DEST_WIDTH = 4,
    parameter int unsigned DEST_BASE  = 0,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic                             i_master_t_valid,
    output logic                             o_master_t_ready,
    input  logic [NASTI_DATA_W-1:0]          i_master_t_data,
    input  logic [NASTI_STRB_W-1:0]          i_master_t_strb,
    input  logic [NASTI_STRB_W-1:0]          i_master_t_keep,
    input  logic                             i_master_t_last,
    input  logic [NASTI_ID_W-1:0]            i_master_t_id,
    input  logic [DEST_WIDTH-1:0]            i_master_t_dest,
    input  logic [NASTI_USER_W-1:0]          i_master_t_user,
    output logic [N_PORT-1:0]                o_slave_t_valid,
    input  logic [N_PORT-1:0]                i_slave_t_ready,
    output logic [N_PORT*NASTI_DATA_W-1:0]   o_slave_t_data,
    output logic [N_PORT*NASTI_STRB_W-1:0]   o_slave_t_strb,
    output logic [N_PORT*NASTI_STRB_W-1:0]   o_slave_t_keep,
    output logic [N_PORT-1:0]                o_slave_t_last,
    output logic [N_PORT*NASTI_ID_W-1:0]     o_slave_t_id,
    output logic [N_PORT*DEST_WIDTH-1:0]     o_slave_t_dest,
    output logic [N_PORT*NASTI_USER_W-1:0]   o_slave_t_user,
    output logic                             o_busy,
    output logic [CNT_WIDTH-1:0]             o_drop_cnt
);

    localparam int unsigned SEL_W = (N_PORT > 1) ? $clog2(N_PORT) : 1;

    stream_beat_t          w_in;
    stream_beat_t          w_core;
    logic                  w_core_valid;
    logic                  w_core_ready;
    logic [DEST_WIDTH-1:0] w_dest;
    logic [DEST_WIDTH-1:0] w_idx;
    logic                  w_in_range;
    logic [SEL_W-1:0]      w_lane;
    logic                  w_route;
    logic                  w_drop_done;
    stream_state_e         w_state_nx;
    stream_state_e         r_state;
    logic [SEL_W-1:0]      r_sel;
    logic [CNT_WIDTH-1:0]  r_drop_cnt;

    assign w_in = '{
        data: i_master_t_data,
        strb: i_master_t_strb,
        keep: i_master_t_keep,
        last: i_master_t_last,
        id:   i_master_t_id,
        dest: NASTI_DEST_W'(i_master_t_dest),
        user: i_master_t_user
    };

`ifdef NASTI_STREAM_DEMUX_REG_SLICE_EN
    nasti_stream_skid_buf #(
        .T(stream_beat_t)
    ) u_skid (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_valid (i_master_t_valid),
        .o_ready (o_master_t_ready),
        .i_beat  (w_in),
        .o_valid (w_core_valid),
        .i_ready (w_core_ready),
        .o_beat  (w_core)
    );
`else
    assign w_core_valid     = i_master_t_valid;
    assign w_core           = w_in;
    assign o_master_t_ready = w_core_ready;
`endif

    // Unsigned subtract wraps below DEST_BASE, so the explicit >= test is still needed.
    assign w_dest     = DEST_WIDTH'(w_core.dest);
    assign w_idx      = w_dest - DEST_WIDTH'(DEST_BASE);
    assign w_in_range = (32'(w_dest) >= DEST_BASE) && (32'(w_idx) < N_PORT);

    always_comb begin
        w_state_nx   = r_state;
        w_lane       = r_sel;
        w_route      = 1'b0;
        w_core_ready = 1'b0;
        w_drop_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_core_valid && w_in_range) begin
                    w_lane       = SEL_W'(w_idx);
                    w_route      = 1'b1;
                    w_core_ready = i_slave_t_ready[w_lane];
                    if (w_core_ready && !w_core.last) w_state_nx = S_ROUTE;
                end else if (w_core_valid) begin
                    w_core_ready = 1'b1;
                    w_drop_done  = w_core.last;
                    if (!w_core.last) w_state_nx = S_DROP;
                end
            end
            S_ROUTE: begin
                w_route      = 1'b1;
                w_core_ready = i_slave_t_ready[r_sel];
                if (w_core_valid && w_core_ready && w_core.last) w_state_nx = S_IDLE;
            end
            S_DROP: begin
                w_core_ready = 1'b1;
                w_drop_done  = w_core_valid && w_core.last;
                if (w_drop_done) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= S_IDLE;
            r_sel      <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == S_IDLE && w_state_nx == S_ROUTE) r_sel <= w_lane;
            if (w_drop_done && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
        end
    end

    // Payload is broadcast; only the selected lane's valid rises.
    assign o_slave_t_valid = (w_route && w_core_valid) ? (N_PORT'(1) << w_lane) : '0;
    assign o_slave_t_data  = {N_PORT{w_core.data}};
    assign o_slave_t_strb  = {N_PORT{w_core.strb}};
    assign o_slave_t_keep  = {N_PORT{w_core.keep}};
    assign o_slave_t_last  = {N_PORT{w_core.last}};
    assign o_slave_t_id    = {N_PORT{w_core.id}};
    assign o_slave_t_dest  = {N_PORT{w_dest}};
    assign o_slave_t_user  = {N_PORT{w_core.user}};
    assign o_busy          = (r_state != S_IDLE);
    assign o_drop_cnt      = r_drop_cnt;

endmodule

// File: doc/nasti_stream_demux.md
Name: nasti_stream_demux

Overview:
Single-input, N-output NASTI stream router; the one-to-many counterpart of the many-to-one stream mux. Each packet is routed by t_dest, sampled on its first beat, to output lane t_dest-DEST_BASE. The route stays locked until the t_last handshake. Packets whose destination falls outside the port range are consumed and discarded, and a counter records each one.

Parameters:
N_PORT, 2, number of output lanes on slave interface (1..16)
DEST_WIDTH, 4, width of t_dest; must hold DEST_BASE+N_PORT-1
DEST_BASE, 0, t_dest value mapped to lane 0
CNT_WIDTH, 16, width of drop counter

Ports:
aclk  input  1  clock
aresetn  input  1  reset, asynchronous, active-low
master  nasti_stream_channel.slave  1 lane  upstream stream; uses t_valid, t_ready, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user
slave  nasti_stream_channel.master  N_PORT lanes  downstream streams, same signal set per lane
busy  output  1  high while a multi-beat packet is mid-transfer (state ROUTE or DROP)
drop_cnt  output  CNT_WIDTH  saturating count of discarded packets

Behaviour:
- Reset: state IDLE; sel=0; drop_cnt=0; all slave.t_valid[i]=0; master.t_ready=0; busy=0.
- Decode: idx = master.t_dest - DEST_BASE, unsigned, DEST_WIDTH bits. The destination is in range iff t_dest >= DEST_BASE and idx < N_PORT.
- FSM states: IDLE, ROUTE, DROP.
- IDLE, with master.t_valid and an in-range destination:
  - route combinationally to lane idx (no bubble).
  - slave.t_valid[idx] = 1; master.t_ready = slave.t_ready[idx].
  - On handshake with !t_last: latch sel=idx, go to ROUTE. With t_last: stay IDLE.
- IDLE, with master.t_valid and an out-of-range destination:
  - master.t_ready = 1; no slave valid.
  - On handshake with t_last: drop_cnt++, stay IDLE. With !t_last: go to DROP.
- ROUTE:
  - lane = sel; t_dest changes on later beats are ignored.
  - slave.t_valid[sel] = master.t_valid; master.t_ready = slave.t_ready[sel].
  - On t_last handshake, go to IDLE. The next packet may handshake on the very next cycle.
- DROP:
  - master.t_ready = 1; all slave valids 0.
  - On t_last handshake: drop_cnt++ (saturate at all-ones), go to IDLE.
- Data signals (t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user) are broadcast to every lane. Only the valid of the selected lane is asserted.
- slave.t_valid never depends on slave.t_ready (AXI-Stream rule). A lane's t_valid and data stay stable while stalled, provided upstream holds them.
- The block adds no buffering: latency is 0 cycles, and throughput is 1 beat/cycle including back-to-back packets.
- master.t_valid=0 in ROUTE/DROP: hold state, assert no valid.
- Reset mid-packet: return to IDLE immediately. The downstream lane sees a truncated packet; this is accepted behaviour, and no recovery is attempted.
- busy = (state != IDLE).

Optional Feature:
NASTI_STREAM_DEMUX_REG_SLICE_EN
- Defined: a 2-entry skid buffer sits between master and the router core.
  - master.t_ready is registered; latency is 1 cycle; full throughput is kept.
  - After reset, master.t_ready=1 on the first cycle. The buffer empties normally on reset.
  - drop_cnt increments 1 cycle later than in the undefined build.
- Undefined: purely combinational datapath as described in Behaviour.

Decomposition:
- nasti_stream_pkg: state enum (IDLE/ROUTE/DROP) and the beat struct {data, strb, keep, last, id, dest, user}, shared with the stream mux.
- Sub-module nasti_stream_skid_buf: 2-entry, parameterised on the beat struct. Instantiated only under the macro.

Test Plan:
- N_PORT=2, DEST_BASE=0, 4-beat packet with t_dest=1, all ready high -> 4 beats on lane 1 in 4 cycles; lane 0 valid never high; busy high for cycles 2-4.
- Packet A (dest 0, 3 beats) immediately followed by B (dest 1, 2 beats) -> 5 consecutive handshakes, no idle cycle, correct lane each.
- Packet dest 0 whose t_dest changes to 1 on beat 2 -> all 3 beats on lane 0.
- dest=5 with N_PORT=2: one 3-beat packet plus one single-beat packet -> master.t_ready=1 throughout, no slave valid, drop_cnt=2.
- Lane 1 t_ready toggles 1,0,0,1 during a 2-beat packet -> master stalls in lockstep, data stable while stalled, beats delivered in order.
- aresetn low after beat 2 of a 4-beat packet -> next cycle: all valids 0, busy 0, drop_cnt 0. A new packet after reset routes correctly.
